// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths, FIPS-197 S-box table and the
// SubBytes sequencer state encoding.
package aes_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES_BYTE_W    = 8;
  localparam int unsigned AES_NUM_BYTES = AES_STATE_W / AES_BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

  // Forward S-box, indexed by input byte value
  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box lookup (purely combinational).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] din,
  output logic [AES_BYTE_W-1:0] dout
);

  assign dout = SBOX_TABLE[din];

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes SBOX_LANES bytes of the working state per
// cycle, MSB byte first, with valid/ready handshakes on input and output.
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] sub_byte,
  output logic                   busy
);

  localparam int unsigned NUM_STEPS = AES_NUM_BYTES / SBOX_LANES;
  localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int unsigned LANE_W    = SBOX_LANES * AES_BYTE_W;
  localparam logic [AES_STATE_W-1:0] LANE_MASK = AES_STATE_W'({LANE_W{1'b1}});

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
        SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_iter: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  sub_state_e             state_q, state_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic [LANE_W-1:0]      lane_in, lane_out;
  int unsigned            lane_shift;

  // Step 0 addresses the most significant lane group
  assign lane_shift = (NUM_STEPS - 1 - 32'(step_q)) * LANE_W;
  assign lane_in    = LANE_W'(work_q >> lane_shift);

  for (genvar i = 0; i < SBOX_LANES; i++) begin : g_lane
    aes_sbox u_sbox (
      .din  (lane_in [i*AES_BYTE_W +: AES_BYTE_W]),
      .dout (lane_out[i*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      work_q  <= work_d;
    end
  end

  // Next-state, working-register update and handshake decode
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = state_in;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy   = 1'b1;
        work_d = (work_q & ~(LANE_MASK << lane_shift)) |
                 (AES_STATE_W'(lane_out) << lane_shift);
        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
          step_d  = '0;
          state_d = ST_DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            work_d  = state_in;
            step_d  = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sub_byte = work_q;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Self-checking bench: five DUTs (SBOX_LANES 4,1,2,8,16) compared every cycle
// against a GF(2^8)-derived S-box model with transaction-level timing.
module tb_aes_sub_bytes_iter;

  localparam int NI = 5;
  localparam int unsigned LANES [NI] = '{4, 1, 2, 8, 16};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [NI];
  logic         out_ready [NI];
  logic [127:0] st_in     [NI];
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic [127:0] sub_byte  [NI];
  logic         busy      [NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    aes_sub_bytes_iter #(.SBOX_LANES(LANES[k])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .state_in  (st_in[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .sub_byte  (sub_byte[k]),
      .busy      (busy[k])
    );
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Transaction model: cycles until result, result-pending flag and value
  int           m_cnt  [NI];
  logic         m_ov   [NI];
  logic [127:0] m_data [NI];
  logic [127:0] m_pend [NI];
  logic         m_rst  [NI];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S(x) = affine(x^-1) over GF(2^8) with the AES polynomial
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[b*8 +: 8] = sbox_f(s[b*8 +: 8]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1
  task automatic cycle();
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        logic exp_ir;
        exp_ir = (m_cnt[k] == 0 && !m_ov[k]) || (m_ov[k] && out_ready[k]);
        chk($sformatf("out_valid[L%0d]", LANES[k]), 128'(out_valid[k]), 128'(m_ov[k]));
        chk($sformatf("busy[L%0d]", LANES[k]), 128'(busy[k]), 128'(m_cnt[k] != 0 || m_ov[k]));
        chk($sformatf("in_ready[L%0d]", LANES[k]), 128'(in_ready[k]), 128'(exp_ir));
        if (m_ov[k] || m_rst[k])
          chk($sformatf("sub_byte[L%0d]", LANES[k]), sub_byte[k], m_data[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_cnt[k] = 0; m_ov[k] = 1'b0; m_data[k] = '0; m_rst[k] = 1'b1;
      end else begin
        logic acc;
        acc = in_valid[k] && ((m_cnt[k] == 0 && !m_ov[k]) || (m_ov[k] && out_ready[k]));
        m_rst[k] = 1'b0;
        if (m_ov[k] && out_ready[k]) m_ov[k] = 1'b0;
        if (m_cnt[k] != 0) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) begin m_ov[k] = 1'b1; m_data[k] = m_pend[k]; end
        end
        if (acc) begin
          m_cnt[k]  = 16 / int'(LANES[k]);
          m_pend[k] = sub_state(st_in[k]);
        end
      end
    end
    chk_en = 1;
    #1;
  endtask

  // Present one block to an idle instance, then wait (bounded) for out_valid
  task automatic run_block(input int k, input logic [127:0] d, output int lat);
    in_valid[k] = 1'b1;
    st_in[k]    = d;
    cycle();
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      cycle();
      lat++;
    end
  endtask

  localparam logic [127:0] VEC   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_S = 128'h638293c31bfc33f5c4eeacea4bc12816;

  initial begin
    int lat;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1; st_in[k] = '0;
      m_cnt[k] = 0; m_ov[k] = 1'b0; m_data[k] = '0; m_pend[k] = '0; m_rst[k] = 1'b0;
    end

    chk("model S(01)", 128'(sbox_f(8'h01)), 128'h7c);
    chk("model S(53)", 128'(sbox_f(8'h53)), 128'hed);
    chk("model vector", sub_state(VEC), VEC_S);

    cycle(); cycle();
    rst_n = 1'b1;
    chk("reset in_ready", 128'(in_ready[0]), 128'h1);
    chk("reset sub_byte", sub_byte[0], 128'h0);
    cycle();

    // Single block, immediate drain
    run_block(0, VEC, lat);
    chk("t1 latency", 128'(lat), 128'd4);
    chk("t1 sub_byte", sub_byte[0], VEC_S);
    cycle();
    chk("t1 out_valid drop", 128'(out_valid[0]), 128'h0);
    chk("t1 idle in_ready", 128'(in_ready[0]), 128'h1);

    // Backpressure hold
    out_ready[0] = 1'b0;
    run_block(0, VEC, lat);
    repeat (10) cycle();
    chk("t2 held out_valid", 128'(out_valid[0]), 128'h1);
    chk("t2 held sub_byte", sub_byte[0], VEC_S);

    // Back-to-back accept on the draining edge
    out_ready[0] = 1'b1;
    run_block(0, 128'h0, lat);
    chk("t3 latency", 128'(lat), 128'd4);
    chk("t3 sub_byte", sub_byte[0], {16{8'h63}});
    cycle();

    // Reset on the second RUN cycle
    in_valid[0] = 1'b1; st_in[0] = VEC;
    cycle();
    in_valid[0] = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t4 out_valid", 128'(out_valid[0]), 128'h0);
    chk("t4 sub_byte", sub_byte[0], 128'h0);
    chk("t4 in_ready", 128'(in_ready[0]), 128'h1);
    run_block(0, {16{8'hff}}, lat);
    chk("t4 latency", 128'(lat), 128'd4);
    chk("t4 sub_byte ff", sub_byte[0], {16{8'h16}});
    cycle();

    // Lane sweep with random payload led by 01 53
    for (int k = 1; k < NI; k++) begin
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[127:112] = 16'h0153;
      run_block(k, d, lat);
      chk($sformatf("t5 latency L%0d", LANES[k]), 128'(lat), 128'(16 / int'(LANES[k])));
      chk($sformatf("t5 head L%0d", LANES[k]), 128'(sub_byte[k][127:112]), 128'h7ced);
      cycle();
    end

    // in_valid toggling with changing data during RUN
    in_valid[0] = 1'b1; st_in[0] = VEC;
    cycle();
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      in_valid[0] = 1'($urandom_range(0, 1));
      st_in[0]    = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      lat++;
    end
    chk("t6 latency", 128'(lat), 128'd4);
    chk("t6 sub_byte", sub_byte[0], VEC_S);
    in_valid[0] = 1'b0;
    cycle(); cycle();

    // Fully random traffic on all instances, occasional reset
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < NI; k++) begin
        in_valid[k]  = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 3) != 0);
        st_in[k]     = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) st_in[k][127:112] = 16'h0153;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
